// File: rtl/dcp_tx_arbiter.sv
// Round-robin arbiter that shares one UART tx handshake (req/type/data/ack)
// among N command processors, routing the ack back only to the granted owner.
module dcp_tx_arbiter #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    type_i,
    input  logic [N*DW-1:0] din_i,
    output logic [N-1:0]    ack_o,
    output logic            req_tx,
    output logic            type_tx,
    output logic [DW-1:0]   dout_tx,
    input  logic            ack_tx,
    output logic [N-1:0]    grant,
    output logic            busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       owner;
    logic [PW-1:0]       pick_idx;
    logic                pick_vld;
    logic [N-1:0][DW-1:0] din_arr;

    assign din_arr = din_i;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!pick_vld && req_i[j]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            grant   <= '0;
            ack_o   <= '0;
            req_tx  <= 1'b0;
            type_tx <= 1'b0;
            dout_tx <= '0;
            busy    <= 1'b0;
        end else begin
            ack_o <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner   <= pick_idx;
                        grant   <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        type_tx <= type_i[pick_idx];
                        dout_tx <= din_arr[pick_idx];
                        req_tx  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ack_tx) begin
                        req_tx <= 1'b0;
                        ack_o  <= grant;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Wait for both sides to let go so a held req/ack can't re-trigger.
                    if (!req_i[owner] && !ack_tx) begin
                        grant <= '0;
                        ptr   <= (owner == PW'(N-1)) ? '0 : owner + 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcp_tx_arbiter.sv
// Directed bench for dcp_tx_arbiter: reset, single transfer, round-robin,
// pointer wrap, held ack and data/withdrawal stability.
module tb_dcp_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [N-1:0]    type_i;
    logic [N*DW-1:0] din_i;
    logic [N-1:0]    ack_o;
    logic            req_tx;
    logic            type_tx;
    logic [DW-1:0]   dout_tx;
    logic            ack_tx;
    logic [N-1:0]    grant;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dcp_tx_arbiter #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .type_i(type_i), .din_i(din_i),
        .ack_o(ack_o), .req_tx(req_tx), .type_tx(type_tx), .dout_tx(dout_tx),
        .ack_tx(ack_tx), .grant(grant), .busy(busy)
    );

    // Advance one edge; inputs driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_i = '0; type_i = '0; din_i = '0; ack_tx = 1'b0;
        step(); step();
        checks++;
        if ({req_tx, type_tx, busy, grant, ack_o, dout_tx} !== '0) begin
            failures++;
            $display("FAIL reset_state: got req_tx=%b type_tx=%b busy=%b grant=%b ack_o=%b dout=%h, want all 0",
                     req_tx, type_tx, busy, grant, ack_o, dout_tx);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({req_tx, busy, grant} !== '0) begin
            failures++;
            $display("FAIL idle_no_req: got req_tx=%b busy=%b grant=%b, want 0", req_tx, busy, grant);
        end
    endtask

    task automatic test_single();
        req_i = 4'b0010; type_i = 4'b0000; din_i[1*DW +: DW] = 32'h44;
        step();
        checks++;
        if ({req_tx, type_tx, busy, grant, dout_tx} !== {1'b1, 1'b0, 1'b1, 4'b0010, 32'h44}) begin
            failures++;
            $display("FAIL single_issue: got req_tx=%b type=%b busy=%b grant=%b dout=%h, want 1 0 1 0010 00000044",
                     req_tx, type_tx, busy, grant, dout_tx);
        end
        step();
        ack_tx = 1'b1;
        step();
        checks++;
        if ({ack_o, req_tx} !== {4'b0010, 1'b0}) begin
            failures++;
            $display("FAIL single_ack: got ack_o=%b req_tx=%b, want 0010 0", ack_o, req_tx);
        end
        ack_tx = 1'b0; req_i = '0;
        step();
        checks++;
        if ({ack_o, grant, busy} !== '0) begin
            failures++;
            $display("FAIL single_release: got ack_o=%b grant=%b busy=%b, want 0", ack_o, grant, busy);
        end
    endtask

    // ptr is 2 here; after a mid-transfer reset requester 0 must win again.
    task automatic test_reset_mid();
        req_i = 4'b0010;
        step();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL mid_pre_grant: got %b want 0010", grant);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req_tx, grant, ack_o, busy} !== '0) begin
            failures++;
            $display("FAIL mid_reset_async: got req_tx=%b grant=%b ack_o=%b busy=%b, want 0",
                     req_tx, grant, ack_o, busy);
        end
        step();
        rst = 1'b0; req_i = 4'b1111;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL mid_ptr_zero: got grant=%b want 0001", grant);
        end
        ack_tx = 1'b1;
        step();
        checks++;
        if (ack_o !== 4'b0001) begin
            failures++;
            $display("FAIL mid_ack: got ack_o=%b want 0001", ack_o);
        end
        ack_tx = 1'b0; req_i = '0;
        step();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int t = 0; t < 5; t++) begin
            req_i = 4'b1111;
            step();
            checks++;
            if (grant !== exp_g[t] || req_tx !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant%0d: got grant=%b req_tx=%b want %b 1", t, grant, req_tx, exp_g[t]);
            end
            step();
            ack_tx = 1'b1;
            step();
            checks++;
            if (ack_o !== exp_g[t]) begin
                failures++;
                $display("FAIL rr_ack%0d: got ack_o=%b want %b", t, ack_o, exp_g[t]);
            end
            ack_tx = 1'b0; req_i = 4'b1111 & ~exp_g[t];
            step();
            checks++;
            if (grant !== 4'b0000) begin
                failures++;
                $display("FAIL rr_idle%0d: got grant=%b want 0000", t, grant);
            end
        end
        req_i = '0;
        step();
    endtask

    task automatic test_ptr_wrap();
        logic [N-1:0] exp_g [3];
        logic [N-1:0] reqs  [3];
        exp_g = '{4'b1000, 4'b0001, 4'b1000};
        reqs  = '{4'b1000, 4'b1001, 4'b1000};
        do_reset();
        for (int t = 0; t < 3; t++) begin
            req_i = reqs[t];
            step();
            checks++;
            if (grant !== exp_g[t]) begin
                failures++;
                $display("FAIL wrap_grant%0d: got %b want %b", t, grant, exp_g[t]);
            end
            ack_tx = 1'b1;
            step();
            ack_tx = 1'b0; req_i = reqs[t] & ~exp_g[t];
            step();
        end
        req_i = '0;
        step();
    endtask

    task automatic test_held_ack();
        int acks;
        do_reset();
        req_i = 4'b0100; type_i = 4'b0100; din_i[2*DW +: DW] = 32'h55;
        step();
        checks++;
        if ({grant, type_tx, dout_tx} !== {4'b0100, 1'b1, 32'h55}) begin
            failures++;
            $display("FAIL held_issue: got grant=%b type=%b dout=%h want 0100 1 00000055", grant, type_tx, dout_tx);
        end
        ack_tx = 1'b1;
        step();
        acks = (ack_o == 4'b0100) ? 1 : 0;
        req_i = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (ack_o != '0) acks++;
            checks++;
            if ({req_tx, busy, grant} !== {1'b0, 1'b1, 4'b0100}) begin
                failures++;
                $display("FAIL held_release%0d: got req_tx=%b busy=%b grant=%b want 0 1 0100", c, req_tx, busy, grant);
            end
        end
        ack_tx = 1'b0;
        step();
        checks++;
        if ({busy, grant} !== '0) begin
            failures++;
            $display("FAIL held_exit: got busy=%b grant=%b want 0", busy, grant);
        end
        step();
        checks++;
        if (req_tx !== 1'b0 || acks != 1) begin
            failures++;
            $display("FAIL held_once: got req_tx=%b ack_pulses=%0d want 0 1", req_tx, acks);
        end
        type_i = '0;
    endtask

    task automatic test_stability();
        int acks;
        acks = 0;
        do_reset();
        req_i = 4'b0001; din_i[0 +: DW] = 32'h1234;
        step();
        din_i[0 +: DW] = 32'hDEAD_BEEF; req_i = '0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({req_tx, dout_tx} !== {1'b1, 32'h1234}) begin
                failures++;
                $display("FAIL stab_hold%0d: got req_tx=%b dout=%h want 1 00001234", c, req_tx, dout_tx);
            end
        end
        ack_tx = 1'b1;
        step();
        if (ack_o == 4'b0001) acks++;
        checks++;
        if (dout_tx !== 32'h1234) begin
            failures++;
            $display("FAIL stab_dout_ack: got %h want 00001234", dout_tx);
        end
        ack_tx = 1'b0;
        step();
        if (ack_o != '0) acks++;
        step();
        checks++;
        if (acks != 1 || grant !== 4'b0000 || req_tx !== 1'b0) begin
            failures++;
            $display("FAIL stab_withdraw: got ack_pulses=%0d grant=%b req_tx=%b want 1 0000 0", acks, grant, req_tx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_round_robin();
        test_ptr_wrap();
        test_held_ack();
        test_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
